// File: rtl/led_blink_arbiter.sv
// led_blink_arbiter: round-robin arbiter that lends one LED to four requesters,
// blinking it blink_num[k] times for the winner, then idling dark for a gap.
module led_blink_arbiter #(
    parameter logic [31:0] SEC_TIME = 32'd50_000_000,
    parameter logic [31:0] GAP_TIME = 32'd100_000_000
) (
    input  logic        sys_clk,
    input  logic        rst,
    input  logic [3:0]  req,
    input  logic [15:0] blink_num,
    output logic [3:0]  grant,
    output logic [3:0]  done,
    output logic        busy,
    output logic        led
);
    localparam logic [31:0] HALF_M1 = SEC_TIME / 32'd2 - 32'd1;
    localparam logic [31:0] GAP_M1  = GAP_TIME - 32'd1;
    typedef enum logic [1:0] {IDLE, ON, OFF, GAP} state_t;
    state_t      state;
    logic [31:0] timer;
    logic [3:0]  cnt;
    logic [1:0]  last;
    logic [1:0]  pick;
    logic [3:0]  pick_num;
    // Scan downward so the nearest requester after last wins.
    always_comb begin
        pick = last;
        for (int i = 3; i >= 0; i--)
            if (req[2'(last + 2'(i) + 2'd1)]) pick = 2'(last + 2'(i) + 2'd1);
        pick_num = blink_num[{pick, 2'b00} +: 4];
    end
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state <= IDLE;
            timer <= '0;
            cnt   <= '0;
            last  <= 2'd3;
            grant <= '0;
            done  <= '0;
            busy  <= 1'b0;
            led   <= 1'b0;
        end else begin
            done <= '0;
            case (state)
                IDLE: if (|req) begin
                    grant <= 4'(1) << pick;
                    last  <= pick;
                    cnt   <= (pick_num == 4'd0) ? 4'd1 : pick_num;
                    led   <= 1'b1;
                    busy  <= 1'b1;
                    timer <= '0;
                    state <= ON;
                end
                ON, OFF: if (!req[last]) begin
                    led   <= 1'b0;
                    grant <= '0;
                    timer <= '0;
                    state <= GAP;
                end else if (timer == HALF_M1) begin
                    timer <= '0;
                    if (state == ON) begin
                        led   <= 1'b0;
                        state <= OFF;
                    end else if (cnt > 4'd1) begin
                        cnt   <= cnt - 4'd1;
                        led   <= 1'b1;
                        state <= ON;
                    end else begin
                        cnt   <= '0;
                        done  <= grant;
                        grant <= '0;
                        state <= GAP;
                    end
                end else begin
                    timer <= timer + 32'd1;
                end
                GAP: if (timer == GAP_M1) begin
                    timer <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end else begin
                    timer <= timer + 32'd1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_led_blink_arbiter.sv
// tb_led_blink_arbiter: queued expected traces per service episode, checked by a
// free-running monitor a little after every rising edge.
module tb_led_blink_arbiter;
    localparam int SEC = 8;
    localparam int GAP = 4;
    logic        sys_clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [15:0] blink_num;
    logic [3:0]  grant;
    logic [3:0]  done;
    logic        busy;
    logic        led;
    logic [9:0]  exp_q[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          last_m = 3;
    int          cyc = 0;

    led_blink_arbiter #(.SEC_TIME(32'(SEC)), .GAP_TIME(32'(GAP))) dut (
        .sys_clk(sys_clk), .rst(rst), .req(req), .blink_num(blink_num),
        .grant(grant), .done(done), .busy(busy), .led(led)
    );

    always #5 sys_clk = ~sys_clk;

    initial forever begin
        logic [9:0] e;
        logic [9:0] g;
        @(posedge sys_clk);
        cyc++;
        #2;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = {grant, done, busy, led};
            vectors++;
            if (g !== e) begin
                miscompares++;
                $display("FAIL outputs cyc=%0d got grant=%b done=%b busy=%b led=%b expected grant=%b done=%b busy=%b led=%b",
                         cyc, g[9:6], g[5:2], g[1], g[0], e[9:6], e[5:2], e[1], e[0]);
            end
        end
    end

    function automatic int winner(input logic [3:0] m);
        for (int i = 1; i <= 4; i++)
            if (m[(last_m + i) % 4]) return (last_m + i) % 4;
        return -1;
    endfunction

    // One service episode from IDLE: expected trace is derived from the blink
    // arithmetic (period SEC, half on / half off), then inputs are walked cycle by cycle.
    task automatic run_ep(input logic [3:0] mask, input logic [15:0] nums,
                          input int abort_at, input int rst_at, input bit noise);
        int k, n, blen, tot;
        logic [3:0] oh;
        logic lb;
        req = mask;
        blink_num = nums;
        if (mask == 4'd0) begin
            exp_q.push_back(10'b0);
            @(negedge sys_clk);
            return;
        end
        k = winner(mask);
        n = int'(nums[4*k +: 4]);
        if (n == 0) n = 1;
        last_m = k;
        oh = 4'(1 << k);
        blen = (rst_at > 0) ? rst_at : (abort_at > 0) ? abort_at : n * SEC;
        for (int t = 1; t <= blen; t++) begin
            lb = ((t - 1) % SEC) < SEC / 2;
            exp_q.push_back({oh, 4'b0, 1'b1, lb});
        end
        if (rst_at > 0) begin
            exp_q.push_back(10'b0);
            tot = blen + 1;
        end else begin
            for (int g = 1; g <= GAP; g++)
                exp_q.push_back({4'b0, (g == 1 && abort_at == 0) ? oh : 4'b0, 1'b1, 1'b0});
            exp_q.push_back(10'b0);
            tot = blen + GAP + 1;
        end
        for (int t = 1; t <= tot; t++) begin
            @(negedge sys_clk);
            if (t == tot) begin
                if (rst_at > 0) begin
                    rst = 1'b0;
                    last_m = 3;
                end
            end else begin
                if (noise) begin
                    req = (4'($urandom) & ~oh) | (req & oh);
                    blink_num = 16'($urandom);
                end
                if (rst_at == 0 && t == abort_at) req[k] = 1'b0;
                if (t == rst_at) rst = 1'b1;
            end
        end
    endtask

    initial begin
        int m, nb, ab, rs;
        logic [15:0] nums;
        rst = 1'b1;
        req = 4'd0;
        blink_num = 16'd0;
        @(negedge sys_clk);
        req = 4'b0001;
        exp_q.push_back(10'b0);
        @(negedge sys_clk);
        rst = 1'b0;
        req = 4'd0;
        repeat (3) run_ep(4'd0, 16'd0, 0, 0, 0);
        repeat (5) run_ep(4'b1111, 16'h1111, 0, 0, 0);
        run_ep(4'b0001, 16'h0002, 0, 0, 0);
        run_ep(4'b0010, 16'h0000, 0, 0, 0);
        run_ep(4'b1000, 16'hF000, 0, 0, 0);
        run_ep(4'b0100, 16'h0300, 2, 0, 0);
        run_ep(4'b0001, 16'h0003, 0, 2, 0);
        run_ep(4'b1001, 16'h1001, 0, 0, 0);
        for (int i = 0; i < 60; i++) begin
            m = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 15));
            nums = 16'($urandom);
            ab = 0;
            rs = 0;
            if (m != 0) begin
                last_m = last_m;
                nb = int'(nums[4 * winner(4'(m)) +: 4]);
                if (nb == 0) nb = 1;
                if ($urandom_range(0, 3) == 0) ab = int'($urandom_range(1, nb * SEC));
                else if ($urandom_range(0, 19) == 0) rs = int'($urandom_range(1, nb * SEC));
            end
            run_ep(4'(m), nums, ab, rs, 1'b1);
        end
        repeat (2) @(negedge sys_clk);
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        miscompares++;
        $display("FAIL watchdog: cycle budget of 50000 exhausted at cyc=%0d", cyc);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/led_blink_arbiter.md
LED_BLINK_ARBITER -- requirements
Module: led_blink_arbiter

Interface
REQ-001 The module SHALL have parameter SEC_TIME, default 32'd50_000_000, giving the clock cycles per blink period (ON + OFF); legal values are even and >= 4.
REQ-002 The module SHALL have parameter GAP_TIME, default 32'd100_000_000, giving the clock cycles of dark gap between serviced requests; legal values are >= 1.
REQ-003 The module SHALL have port sys_clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The module SHALL have port req, input, 4 bits: level request per requester k; held high until serviced.
REQ-006 The module SHALL have port blink_num, input, 16 bits: blink count for requester k in bits [4k+3:4k], unsigned.
REQ-007 The module SHALL have port grant, output, 4 bits: one-hot owner of the LED, all zero when no owner.
REQ-008 The module SHALL have port done, output, 4 bits: one-cycle completion pulse for requester k.
REQ-009 The module SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-010 The module SHALL have port led, output, 1 bit: the shared LED drive, active-high.
REQ-011 All outputs SHALL be registered.

Function
REQ-012 The FSM SHALL have the states IDLE, ON, OFF and GAP, with one 32-bit phase timer and one 4-bit remaining-blink counter.
REQ-013 In IDLE, at an edge where req != 0, the block SHALL grant round-robin: the search starts at index last+1 mod 4, where last is the most recently granted index.
REQ-014 On that same edge it SHALL set grant to one-hot(k), update last to k, latch n = blink_num[k], set led to 1, clear the timer, and enter ON.
REQ-015 A latched n = 0 SHALL be treated as n = 1; the maximum is 15 blinks.
REQ-016 ON SHALL last exactly SEC_TIME/2 cycles with led = 1, then enter OFF with led = 0.
REQ-017 OFF SHALL last exactly SEC_TIME/2 cycles, then decrement the remaining count.
REQ-018 At the end of OFF, if the remaining count is > 0 the block SHALL return to ON; otherwise it SHALL enter GAP.
REQ-019 On normal completion, at the edge entering GAP, the block SHALL pulse done[k] for exactly 1 cycle and clear grant to 0.
REQ-020 GAP SHALL last exactly GAP_TIME cycles with led = 0, then enter IDLE; requests are not sampled during GAP.
REQ-021 Abort: if req[k] of the current owner is low at any edge in ON or OFF, the block SHALL on that edge set led = 0, clear grant, enter GAP, and not pulse done.
REQ-022 Changes to req or blink_num of non-owners during ON, OFF or GAP SHALL have no effect, and blink_num changes of the owner after the grant edge SHALL be ignored.
REQ-023 In IDLE with req = 0, the block SHALL hold led = 0, grant = 0 and busy = 0.
REQ-024 At most one done bit SHALL be high at any cycle, and grant SHALL never have more than one bit set.
REQ-025 Timer compares SHALL be full 32-bit unsigned, with no wrap-around within legal parameter values.

Reset
REQ-026 With rst high at an edge, the block SHALL enter IDLE and set led = 0, grant = 0, done = 0, busy = 0, the timer to 0 and the counter to 0, with last = 3 so that req[0] has first priority.
REQ-027 Reset SHALL override every state, including mid-ON, OFF or GAP, and SHALL take precedence over a simultaneous request.

Verification (SEC_TIME=8, GAP_TIME=4)
REQ-028 The bench SHALL cover: req=4'b0001, blink_num[3:0]=2 -> led 4 high, 4 low, 4 high, 4 low; then done[0] for 1 cycle; then 4 gap cycles; busy high for 20 cycles total.
REQ-029 The bench SHALL cover: req=4'b1111 held, all counts 1 -> grant sequence 0001, 0010, 0100, 1000, 0001, each 8 cycles, separated by 4-cycle gaps.
REQ-030 The bench SHALL cover: req[2] owner dropped on the 2nd ON cycle -> led 0 and grant 0 next cycle, no done, 4 gap cycles, then IDLE.
REQ-031 The bench SHALL cover: blink_num[7:4]=0 with req[1] -> exactly one blink (4 high, 4 low), then done[1].
REQ-032 The bench SHALL cover: blink_num[15:12]=15 -> exactly 15 ON pulses of 4 cycles each, then done[3].
REQ-033 The bench SHALL cover: rst pulsed mid-ON, then req=4'b1001 -> after reset all outputs 0 and the first grant is 0001.
